// File: rtl/mpu_extern_packetizer.sv
// Host-side packetizer for the MPU external data service: descriptor to header/payload word stream,
// with load returns buffered in a response FIFO. Optional load watchdog: MPU_EXTERN_PKT_TIMEOUT_EN.
package pkg_tpu;
  localparam int WIDTH_DATA = 32;
  typedef logic [WIDTH_DATA-1:0] data_t;
endpackage

module mpu_extern_packetizer
  import pkg_tpu::*;
#(
  parameter int    RESP_DEPTH     = 16,
  parameter data_t INIT_TOKEN     = '0,
  parameter int    TIMEOUT_CYCLES = 1024
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  I_Cmd_Valid,
  output logic  O_Cmd_Ready,
  input  logic  I_Cmd_Dir,
  input  data_t I_Cmd_Stride,
  input  data_t I_Cmd_Length,
  input  data_t I_Cmd_Base,
  input  logic  I_Wr_Valid,
  output logic  O_Wr_Ready,
  input  data_t I_Wr_Data,
  output logic  O_Rd_Valid,
  input  logic  I_Rd_Ready,
  output data_t O_Rd_Data,
  output logic  O_Req,
  output data_t O_Data,
  input  logic  I_Req,
  input  data_t I_Data,
  output logic  O_Busy,
  output logic  O_Done,
  output logic  O_Error
);

  typedef enum logic [2:0] {
    IDLE, H_INIT, H_STRIDE, H_LEN, H_BASE, ST_DATA, LD_DATA, DONE
  } state_t;

  localparam int             PTR_W      = $clog2(RESP_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(RESP_DEPTH);

  state_t                state, state_next;
  logic                  dir_q;
  logic [WIDTH_DATA-2:0] stride_q;
  data_t                 length_q, base_q, count_q;
  logic                  error_q;
  data_t                 resp_mem [RESP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        occupancy;

  logic cmd_accept, wr_fire, rd_return, fifo_empty, fifo_full;
  logic push, pop, overflow, last_word, timeout_hit;

  // The stride MSB position carries the direction bit in the header word.
  logic stride_msb_unused;
  assign stride_msb_unused = I_Cmd_Stride[WIDTH_DATA-1];

  assign fifo_empty  = (occupancy == '0);
  assign fifo_full   = (occupancy == FULL_COUNT);
  assign O_Cmd_Ready = (state == IDLE) && fifo_empty;
  assign cmd_accept  = I_Cmd_Valid && O_Cmd_Ready;
  assign wr_fire     = (state == ST_DATA) && I_Wr_Valid;
  assign rd_return   = (state == LD_DATA) && I_Req;
  assign pop         = !fifo_empty && I_Rd_Ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push        = rd_return && (!fifo_full || pop);
  assign overflow    = rd_return && fifo_full && !pop;
  assign last_word   = (count_q == length_q);

  assign O_Rd_Valid  = !fifo_empty;
  assign O_Rd_Data   = fifo_empty ? '0 : resp_mem[rd_ptr];
  assign O_Busy      = (state != IDLE);
  assign O_Done      = (state == DONE);
  assign O_Error     = error_q;

`ifdef MPU_EXTERN_PKT_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // Held at zero outside LD_DATA, so it starts cleared on every entry.
  always_ff @(posedge clock) begin
    if (reset || (state != LD_DATA) || I_Req) idle_cnt <= '0;
    else                                      idle_cnt <= idle_cnt + 32'd1;
  end

  assign timeout_hit = (state == LD_DATA) && !I_Req && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    O_Req      = 1'b0;
    O_Data     = '0;
    O_Wr_Ready = 1'b0;
    unique case (state)
      IDLE: if (cmd_accept) state_next = H_INIT;
      H_INIT: begin
        O_Req      = 1'b1;
        O_Data     = INIT_TOKEN;
        state_next = H_STRIDE;
      end
      H_STRIDE: begin
        O_Req      = 1'b1;
        O_Data     = {dir_q, stride_q};
        state_next = H_LEN;
      end
      H_LEN: begin
        O_Req      = 1'b1;
        O_Data     = length_q;
        state_next = H_BASE;
      end
      H_BASE: begin
        O_Req      = 1'b1;
        O_Data     = base_q;
        state_next = dir_q ? LD_DATA : ST_DATA;
      end
      ST_DATA: begin
        O_Wr_Ready = 1'b1;
        O_Req      = I_Wr_Valid;
        if (I_Wr_Valid) O_Data = I_Wr_Data;
        if (wr_fire && last_word) state_next = DONE;
      end
      LD_DATA: if ((rd_return && last_word) || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dir_q     <= 1'b0;
      stride_q  <= '0;
      length_q  <= '0;
      base_q    <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (cmd_accept) begin
        dir_q    <= I_Cmd_Dir;
        stride_q <= I_Cmd_Stride[WIDTH_DATA-2:0];
        length_q <= I_Cmd_Length;
        base_q   <= I_Cmd_Base;
        count_q  <= '0;
        error_q  <= 1'b0;
      end else begin
        // Dropped load words still count, so a transfer always ends after Length+1 returns.
        if (wr_fire || rd_return)    count_q <= count_q + data_t'(1);
        if (overflow || timeout_hit) error_q <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   occupancy <= occupancy + (PTR_W + 1)'(1);
        2'b01:   occupancy <= occupancy - (PTR_W + 1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and occupancy define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) resp_mem[wr_ptr] <= I_Data;
  end

endmodule

// File: tb/tb_mpu_extern_packetizer.sv
// Self-checking bench for mpu_extern_packetizer: table-driven descriptors, corner sequences,
// and randomized transfers scored against a queue-based model of the stream and response FIFO.
module tb_mpu_extern_packetizer;
  import pkg_tpu::*;

  localparam int    DEPTH = 16;
  localparam data_t TOKEN = 32'hA5A5_0001;
  localparam int    TMO   = 16;

  logic  clock = 1'b0;
  logic  reset;
  logic  I_Cmd_Valid, O_Cmd_Ready, I_Cmd_Dir;
  data_t I_Cmd_Stride, I_Cmd_Length, I_Cmd_Base;
  logic  I_Wr_Valid, O_Wr_Ready;
  data_t I_Wr_Data;
  logic  O_Rd_Valid, I_Rd_Ready;
  data_t O_Rd_Data;
  logic  O_Req, I_Req;
  data_t O_Data, I_Data;
  logic  O_Busy, O_Done, O_Error;

  always #5 clock = ~clock;

  mpu_extern_packetizer #(
    .RESP_DEPTH(DEPTH), .INIT_TOKEN(TOKEN), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .I_Cmd_Valid(I_Cmd_Valid), .O_Cmd_Ready(O_Cmd_Ready), .I_Cmd_Dir(I_Cmd_Dir),
    .I_Cmd_Stride(I_Cmd_Stride), .I_Cmd_Length(I_Cmd_Length), .I_Cmd_Base(I_Cmd_Base),
    .I_Wr_Valid(I_Wr_Valid), .O_Wr_Ready(O_Wr_Ready), .I_Wr_Data(I_Wr_Data),
    .O_Rd_Valid(O_Rd_Valid), .I_Rd_Ready(I_Rd_Ready), .O_Rd_Data(O_Rd_Data),
    .O_Req(O_Req), .O_Data(O_Data), .I_Req(I_Req), .I_Data(I_Data),
    .O_Busy(O_Busy), .O_Done(O_Done), .O_Error(O_Error)
  );

  int    checks = 0, errors = 0, cyc = 0;
  int    done_n = 0, done_cyc = -1, zero_bad = 0;
  data_t req_q[$], rd_q[$], exp_req[$], exp_rd[$], model_q[$], pay[$];
  bit    m_err;

  typedef struct {
    logic  dir;
    data_t stride, len, base, exp_sw;
    int    rd_mode;
    int    exp_lat;
  } vec_t;
  vec_t vecs[6];

  always @(posedge clock) cyc <= cyc + 1;

  // Passive monitor, sampled on the falling edge.
  always @(negedge clock) begin
    if (O_Req) req_q.push_back(O_Data);
    else if (O_Data != '0) zero_bad++;
    if (O_Done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (O_Rd_Valid && I_Rd_Ready) rd_q.push_back(O_Rd_Data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic compare_q(input string tag, input data_t act[$], input data_t exp[$]);
    check({tag, "_count"}, act.size(), exp.size());
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      check($sformatf("%s_word%0d", tag, i), act[i], exp[i]);
  endtask

  function automatic data_t stride_word(input logic dir, input data_t stride);
    return (dir ? 32'h8000_0000 : 32'h0) + (stride % 32'h8000_0000);
  endfunction

  task automatic expect_header(input data_t exp_sw, input data_t len, input data_t base);
    exp_req.delete();
    exp_req.push_back(TOKEN);
    exp_req.push_back(exp_sw);
    exp_req.push_back(len);
    exp_req.push_back(base);
  endtask

  // Presents one descriptor in the current (idle) cycle; returns at the start of the init-word cycle.
  task automatic start_desc(input logic dir, input data_t stride, input data_t len, input data_t base,
                            output int t);
    check("cmd_ready_idle", O_Cmd_Ready, 1'b1);
    I_Cmd_Valid  = 1'b1;
    I_Cmd_Dir    = dir;
    I_Cmd_Stride = stride;
    I_Cmd_Length = len;
    I_Cmd_Base   = base;
    req_q.delete();
    rd_q.delete();
    done_n = 0;
    t = cyc;
    @(posedge clock); #1;
    I_Cmd_Valid  = 1'b0;
    I_Cmd_Dir    = $urandom_range(0, 1);
    I_Cmd_Stride = $urandom;
    I_Cmd_Length = $urandom;
    I_Cmd_Base   = $urandom;
  endtask

  // mode 0: always valid, 1: valid on odd cycles, 2: random valid.
  task automatic do_store(input data_t stride, input data_t len, input data_t base, input data_t exp_sw,
                          input int mode, input string tag, output int lat);
    int t, k, budget, t_last;
    bit v, hs;
    pay.delete();
    for (int i = 0; i <= int'(len); i++) pay.push_back($urandom);
    start_desc(1'b0, stride, len, base, t);
    check({tag, "_busy"}, O_Busy, 1'b1);
    check({tag, "_err_clr"}, O_Error, 1'b0);
    k = 0;
    t_last = -1;
    budget = 4 * int'(len) + 40;
    while (done_n == 0 && budget > 0) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 1);
        default: v = 1'($urandom_range(0, 1));
      endcase
      I_Wr_Valid = v;
      I_Wr_Data  = (k <= int'(len)) ? pay[k] : data_t'($urandom);
      #1;
      hs = v && O_Wr_Ready;
      if (hs) t_last = cyc;
      @(posedge clock); #1;
      if (hs) k++;
      budget--;
    end
    I_Wr_Valid = 1'b0;
    I_Wr_Data  = $urandom;
    repeat (2) @(posedge clock);
    #1;
    expect_header(exp_sw, len, base);
    foreach (pay[i]) exp_req.push_back(pay[i]);
    compare_q({tag, "_stream"}, req_q, exp_req);
    check({tag, "_done_n"}, done_n, 1);
    check({tag, "_done_at"}, done_cyc, t_last + 1);
    check({tag, "_busy_end"}, O_Busy, 1'b0);
    check({tag, "_err_end"}, O_Error, 1'b0);
    lat = done_cyc - t;
  endtask

  // One load-side cycle: drive the service/host inputs and advance the FIFO model.
  task automatic load_cycle(input bit req, input bit in_ld, input bit rd);
    bit full, popped;
    I_Req      = req;
    I_Data     = $urandom;
    I_Rd_Ready = rd;
    full   = (model_q.size() == DEPTH);
    popped = (model_q.size() > 0) && rd;
    if (popped) exp_rd.push_back(model_q.pop_front());
    if (req && in_ld) begin
      if (!full || popped) model_q.push_back(I_Data);
      else m_err = 1'b1;
    end
    @(posedge clock); #1;
  endtask

  function automatic bit rd_pick(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  // rd_mode 0: host always ready, 1: never ready until the transfer ends, 2: random.
  task automatic do_load(input data_t stride, input data_t len, input data_t base, input data_t exp_sw,
                         input int rd_mode, input bit gaps, input string tag);
    int  t, t_last, sent, budget;
    bit  r;
    model_q.delete();
    exp_rd.delete();
    m_err  = 1'b0;
    t_last = -1;
    sent   = 0;
    start_desc(1'b1, stride, len, base, t);
    // Returns during the header are not in LD_DATA and must be discarded.
    for (int i = 0; i < 4; i++) load_cycle(1'b1, 1'b0, rd_pick(rd_mode));
    budget = 4 * int'(len) + 40;
    while (sent <= int'(len) && budget > 0) begin
      r = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (r) begin
        sent++;
        t_last = cyc;
      end
      load_cycle(r, 1'b1, rd_pick(rd_mode));
      budget--;
    end
    load_cycle(1'b1, 1'b0, rd_pick(rd_mode));
    if (rd_mode == 1) begin
      load_cycle(1'b0, 1'b0, 1'b0);
      load_cycle(1'b0, 1'b0, 1'b0);
      check({tag, "_ready_held"}, O_Cmd_Ready, model_q.size() == 0);
    end
    budget = 3 * DEPTH;
    while (model_q.size() > 0 && budget > 0) begin
      load_cycle(1'b0, 1'b0, 1'b1);
      budget--;
    end
    I_Rd_Ready = 1'b0;
    expect_header(exp_sw, len, base);
    compare_q({tag, "_hdr"}, req_q, exp_req);
    compare_q({tag, "_rd"}, rd_q, exp_rd);
    check({tag, "_done_n"}, done_n, 1);
    check({tag, "_done_at"}, done_cyc, t_last + 1);
    check({tag, "_err"}, O_Error, m_err);
    check({tag, "_rd_valid_end"}, O_Rd_Valid, 1'b0);
    check({tag, "_ready_end"}, O_Cmd_Ready, 1'b1);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int t, lat;
    reset        = 1'b1;
    I_Cmd_Valid  = 1'b0;
    I_Cmd_Dir    = 1'b0;
    I_Cmd_Stride = '0;
    I_Cmd_Length = '0;
    I_Cmd_Base   = '0;
    I_Wr_Valid   = 1'b0;
    I_Wr_Data    = '0;
    I_Rd_Ready   = 1'b0;
    I_Req        = 1'b0;
    I_Data       = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    check("rst_cmd_ready", O_Cmd_Ready, 1'b1);
    check("rst_req", O_Req, 1'b0);
    check("rst_data", O_Data, 32'h0);
    check("rst_wr_ready", O_Wr_Ready, 1'b0);
    check("rst_rd_valid", O_Rd_Valid, 1'b0);
    check("rst_rd_data", O_Rd_Data, 32'h0);
    check("rst_busy", O_Busy, 1'b0);
    check("rst_done", O_Done, 1'b0);
    check("rst_error", O_Error, 1'b0);

    vecs[0] = '{1'b0, 32'd4,          32'd3,  32'h100,       32'h0000_0004, 0, 9};
    vecs[1] = '{1'b1, 32'd1,          32'd7,  32'h2000,      32'h8000_0001, 0, 0};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF,  32'd0,  32'h0,         32'h7FFF_FFFF, 0, 6};
    vecs[3] = '{1'b1, 32'h8000_0005,  32'd2,  32'hABC,       32'h8000_0005, 2, 0};
    vecs[4] = '{1'b0, 32'h0001_2345,  32'd5,  32'hDEAD_0000, 32'h0001_2345, 0, 11};
    vecs[5] = '{1'b1, 32'd3,          32'd15, 32'h40,        32'h8000_0003, 1, 0};
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].dir) begin
        do_load(vecs[i].stride, vecs[i].len, vecs[i].base, vecs[i].exp_sw,
                vecs[i].rd_mode, vecs[i].rd_mode == 2, $sformatf("vec%0d", i));
      end else begin
        do_store(vecs[i].stride, vecs[i].len, vecs[i].base, vecs[i].exp_sw, 0,
                 $sformatf("vec%0d", i), lat);
        check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      end
    end

    // Overflow: 20 returns into a 16-entry FIFO with the host stalled.
    do_load(32'd1, 32'd19, 32'h300, 32'h8000_0001, 1, 1'b0, "ovf");
    check("ovf_rd_count", rd_q.size(), 16);
    check("ovf_err_sticky", O_Error, 1'b1);

    // Sticky error clears on the next accept; host valid toggles.
    do_store(32'd2, 32'd1, 32'h55, 32'h0000_0002, 1, "st_toggle", lat);
    check("toggle_words", req_q.size(), 6);

    // Reset in the middle of the header.
    start_desc(1'b0, 32'd4, 32'd3, 32'h100, t);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("hlen_data", O_Data, 32'd3);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst_mid_req", O_Req, 1'b0);
    check("rst_mid_busy", O_Busy, 1'b0);
    check("rst_mid_ready", O_Cmd_Ready, 1'b1);
    repeat (8) @(posedge clock);
    #1;
    check("rst_mid_no_done", done_n, 0);
    do_store(32'd4, 32'd3, 32'h100, 32'h0000_0004, 0, "after_rst", lat);
    check("after_rst_latency", lat, 9);

    for (int n = 0; n < 10; n++) begin
      logic  d;
      data_t s, l, b;
      d = 1'($urandom_range(0, 1));
      s = $urandom;
      l = $urandom_range(0, 22);
      b = $urandom;
      if (d) do_load(s, l, b, stride_word(d, s), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                     $sformatf("rnd%0d", n));
      else   do_store(s, l, b, stride_word(d, s), $urandom_range(0, 2), $sformatf("rnd%0d", n), lat);
    end

`ifdef MPU_EXTERN_PKT_TIMEOUT_EN
    begin
      int b;
      b = 0;
      start_desc(1'b1, 32'd1, 32'd5, 32'h0, t);
      while (done_n == 0 && b < 60) begin
        load_cycle(1'b0, 1'b0, 1'b1);
        b++;
      end
      check("tmo_done_at", done_cyc, t + 5 + TMO);
      check("tmo_err", O_Error, 1'b1);
    end
`endif

    check("zero_when_idle", zero_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpu_extern_packetizer.md
# mpu_extern_packetizer

Host-side front end of the MPU external data service. Converts one host transfer descriptor into the serial word stream the MPU data service consumes: init token, direction/stride, length, base, then store payload. For load transfers it collects the words returned by the data service into a response FIFO and hands them to the host on a valid/ready port.

## Interface
Parameters:
- RESP_DEPTH, 16, response FIFO entries, power of two, ≥ 2
- INIT_TOKEN, 0, value driven on O_Data during the init word
- TIMEOUT_CYCLES, 1024, load watchdog limit; used only with MPU_EXTERN_PKT_TIMEOUT_EN

Ports (data_t = WIDTH_DATA bits from pkg_tpu):
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- I_Cmd_Valid  in  1  descriptor valid
- O_Cmd_Ready  out  1  descriptor accepted when both are high
- I_Cmd_Dir  in  1  1 = load (memory to host), 0 = store
- I_Cmd_Stride  in  data_t  access stride; only bits [WIDTH_DATA-2:0] are used
- I_Cmd_Length  in  data_t  word count minus 1 (N-1)
- I_Cmd_Base  in  data_t  base address
- I_Wr_Valid / O_Wr_Ready / I_Wr_Data  in/out/in  1/1/data_t  store payload from host
- O_Rd_Valid / I_Rd_Ready / O_Rd_Data  out/in/out  1/1/data_t  load data to host
- O_Req / O_Data  out  1/data_t  word stream to the data service (I_Req/I_Data)
- I_Req / I_Data  in  1/data_t  returned words from the data service (O_Req/O_Data)
- O_Busy  out  1  high in every state except IDLE
- O_Done  out  1  one-cycle pulse at transfer end
- O_Error  out  1  sticky; set on response overflow or timeout, cleared on the next descriptor accept

## Operation
- FSM states: IDLE, H_INIT, H_STRIDE, H_LEN, H_BASE, ST_DATA, LD_DATA, DONE.
- IDLE: O_Cmd_Ready = response FIFO empty. On accept, register Dir, Stride, Length, Base. Clear the word counter and O_Error. Go to H_INIT.
- H_INIT → H_STRIDE → H_LEN → H_BASE, unconditionally, one cycle each. O_Req = 1 in each state. O_Data is, in order:
  - INIT_TOKEN
  - {Dir, Stride[WIDTH_DATA-2:0]}
  - Length
  - Base
- After H_BASE: go to LD_DATA if Dir = 1, otherwise ST_DATA.
- ST_DATA:
  - O_Wr_Ready = 1. O_Req = I_Wr_Valid. O_Data = I_Wr_Data, combinational pass-through.
  - The counter increments on each handshake.
  - The handshake with counter == Length goes to DONE.
- LD_DATA:
  - Each I_Req pushes I_Data into the response FIFO. The counter increments on each push.
  - The push with counter == Length goes to DONE.
  - I_Req while the FIFO is full: the word is dropped, O_Error is set, and the counter still increments.
- DONE: O_Done = 1 for one cycle, then IDLE.
- Response FIFO:
  - Pointers are log2(RESP_DEPTH) bits and wrap modulo RESP_DEPTH. Occupancy count is one bit wider.
  - O_Rd_Valid = ~empty. O_Rd_Data is the head entry.
  - A pop occurs when O_Rd_Valid & I_Rd_Ready.
  - Push and pop in the same cycle while full: the pop frees the entry, and the push succeeds with no error.
- Counter width is WIDTH_DATA. Length 0 means one word. The counter never wraps within one transfer.
- I_Req outside LD_DATA is ignored and the word is discarded.
- O_Data is 0 whenever O_Req is 0.

## Timing
- Reset values: FSM IDLE; O_Cmd_Ready 1, O_Req 0, O_Data 0, O_Wr_Ready 0, O_Rd_Valid 0, O_Rd_Data don't-care (0 after reset), O_Busy 0, O_Done 0, O_Error 0; FIFO empty, counter 0.
- Accept at cycle t: init word at t+1, base word at t+4. The first payload word can appear at t+5.
- Store of N words at full host rate: O_Done at t+5+N.
- Load: a word pushed at cycle c is visible on O_Rd_Valid at c+1.
- Reset mid-transfer aborts the transfer: the FIFO is flushed, no O_Done is produced, and O_Req is 0 in the cycle after reset.

## Configuration
- MPU_EXTERN_PKT_TIMEOUT_EN defined:
  - An idle counter runs in LD_DATA. It clears on each I_Req and on entry to LD_DATA.
  - Reaching TIMEOUT_CYCLES sets O_Error and forces DONE, with O_Done pulsed.
- Not defined: no counter is built, and LD_DATA waits indefinitely. O_Error reflects overflow only.

## Test plan
- Store, Dir=0, Stride=4, Length=3, Base=0x100, host always valid → O_Req stream INIT_TOKEN, 0x00000004, 3, 0x100, then 4 payload words on consecutive cycles; O_Done at t+9.
- Load, Dir=1, Stride=1, Length=7 → stride word 0x80000001; 8 returned words A0..A7 read out in order with I_Rd_Ready=1; O_Done once, O_Error 0.
- Load, Length=19, RESP_DEPTH=16, I_Rd_Ready=0 → 16 words stored; 4 dropped; O_Error=1; O_Done pulsed; O_Cmd_Ready stays 0 until the FIFO is drained.
- Store with I_Wr_Valid toggling every other cycle, Length=1 → O_Req only on valid cycles; exactly 2 payload words; no extra O_Req.
- Reset asserted during H_LEN → next cycle O_Req=0, O_Busy=0, O_Cmd_Ready=1; a new descriptor then runs normally.
- With MPU_EXTERN_PKT_TIMEOUT_EN, TIMEOUT_CYCLES=16, load with no returns → O_Error and O_Done after 16 cycles in LD_DATA.
